// File: rtl/audio_dsp_pkg.sv
// Shared constants, FSM encoding and round/saturate helper for the audio DSP chunk stages.
package audio_dsp_pkg;

    localparam int unsigned SAMPLE_W  = 24;
    localparam int unsigned BUF_DEPTH = 64;
    localparam int unsigned PTR_W     = 6;
    localparam int unsigned GAIN_W    = 16;
    localparam int unsigned Q_SHIFT   = 14;
    localparam int unsigned PROD_W    = SAMPLE_W + GAIN_W;

    localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(BUF_DEPTH - 1);

    localparam logic signed [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [PROD_W:0]     SAT_HI_W = (PROD_W+1)'(SAT_MAX);
    localparam logic signed [PROD_W:0]     SAT_LO_W = (PROD_W+1)'(SAT_MIN);
    localparam logic signed [PROD_W:0]     ROUND_BIAS =
        {{(PROD_W+1-Q_SHIFT){1'b0}}, 1'b1, {(Q_SHIFT-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Round half up in Qx.14, then clamp; one extra bit of headroom keeps the bias add from wrapping.
    function automatic logic signed [SAMPLE_W-1:0] round_sat(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W:0] sum;
        logic signed [PROD_W:0] shifted;
        sum     = {p[PROD_W-1], p} + ROUND_BIAS;
        shifted = sum >>> Q_SHIFT;
        if (shifted > SAT_HI_W)
            return SAT_MAX;
        else if (shifted < SAT_LO_W)
            return SAT_MIN;
        else
            return shifted[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// 2-FF synchronizer plus registered rising-edge detector; one-clk pulse 3 clk after the input edge.
module pulse_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_in};
            prev_q <= sync_q[1];
            pulse  <= sync_q[1] & ~prev_q;
        end
    end

endmodule

// File: rtl/chunk_gain_processor.sv
// Chunk gain stage: reads BUF_DEPTH rx samples, applies Q2.14 gain with round/saturate, writes tx buffer.
// Optional CHUNK_PEAK_EN adds peak_abs, the post-saturation max |out_sample| of the last chunk.
module chunk_gain_processor
    import audio_dsp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                chunk_pulse,
    input  logic [GAIN_W-1:0]   gain,
    output logic [PTR_W-1:0]    in_addr,
    input  logic [SAMPLE_W-1:0] in_sample,
    output logic [PTR_W-1:0]    out_addr,
    output logic [SAMPLE_W-1:0] out_sample,
    output logic                out_we,
    output logic                busy,
    output logic                done,
    output logic                overrun
`ifdef CHUNK_PEAK_EN
    ,
    output logic [SAMPLE_W-2:0] peak_abs
`endif
);

    state_t                     state, state_nxt;
    logic                       start;
    logic [1:0]                 drain_cnt;
    logic signed [GAIN_W-1:0]   gain_lat;
    logic                       v1, v2;
    logic [PTR_W-1:0]           a1, a2;
    logic signed [PROD_W-1:0]   product;
    logic signed [SAMPLE_W-1:0] y_next;

    pulse_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (chunk_pulse),
        .pulse    (start)
    );

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        y_next    = round_sat(product);
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (in_addr == LAST_ADDR) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == 2'd2) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Issue in cycle k, rx buffer data valid k+1, product k+2, write k+3.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            in_addr    <= '0;
            gain_lat   <= '0;
            drain_cnt  <= '0;
            overrun    <= 1'b0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            a1         <= '0;
            a2         <= '0;
            product    <= '0;
            out_we     <= 1'b0;
            out_addr   <= '0;
            out_sample <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                gain_lat <= gain;
                in_addr  <= '0;
            end else if (state == ST_RUN && in_addr != LAST_ADDR) begin
                in_addr <= in_addr + 1'b1;
            end
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (start && state != ST_IDLE)
                overrun <= 1'b1;

            v1         <= (state == ST_RUN);
            a1         <= in_addr;
            v2         <= v1;
            a2         <= a1;
            product    <= PROD_W'(signed'(in_sample)) * PROD_W'(gain_lat);
            out_we     <= v2;
            out_addr   <= a2;
            out_sample <= y_next;
        end
    end

`ifdef CHUNK_PEAK_EN
    logic [SAMPLE_W-2:0] run_peak;
    logic [SAMPLE_W-2:0] cur_abs;

    // |SAT_MIN| does not fit in SAMPLE_W-1 bits, so it is clamped to the positive limit.
    always_comb begin
        cur_abs = y_next[SAMPLE_W-2:0];
        if (y_next == SAT_MIN)
            cur_abs = '1;
        else if (y_next[SAMPLE_W-1])
            cur_abs = ~y_next[SAMPLE_W-2:0] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_peak <= '0;
            peak_abs <= '0;
        end else begin
            if (state == ST_IDLE && start)
                run_peak <= '0;
            else if (v2 && cur_abs > run_peak)
                run_peak <= cur_abs;
            if (state == ST_DRAIN && state_nxt == ST_DONE)
                peak_abs <= run_peak;
        end
    end
`endif

endmodule

// File: tb/tb_chunk_gain_processor.sv
// Directed self-checking bench for chunk_gain_processor with a registered-read rx buffer model.
module tb_chunk_gain_processor;
    import audio_dsp_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                chunk_pulse = 1'b0;
    logic [GAIN_W-1:0]   gain = '0;
    logic [PTR_W-1:0]    in_addr;
    logic [SAMPLE_W-1:0] in_sample = '0;
    logic [PTR_W-1:0]    out_addr;
    logic [SAMPLE_W-1:0] out_sample;
    logic                out_we, busy, done, overrun;
`ifdef CHUNK_PEAK_EN
    logic [SAMPLE_W-2:0] peak_abs;
    logic [SAMPLE_W-2:0] peak_at_done = '0;
`endif

    chunk_gain_processor dut (
`ifdef CHUNK_PEAK_EN
        .peak_abs    (peak_abs),
`endif
        .clk         (clk),
        .rst_n       (rst_n),
        .chunk_pulse (chunk_pulse),
        .gain        (gain),
        .in_addr     (in_addr),
        .in_sample   (in_sample),
        .out_addr    (out_addr),
        .out_sample  (out_sample),
        .out_we      (out_we),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    always #10 clk = ~clk;

    logic [SAMPLE_W-1:0] mem [BUF_DEPTH];
    always @(posedge clk) in_sample <= mem[in_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor samples 1 time unit after each rising edge.
    int                  cyc = 0;
    int                  wr_cnt = 0;
    int                  done_cnt = 0;
    int                  done_cyc = 0;
    int                  first_issue_cyc = 0;
    logic [PTR_W-1:0]    first_addr = '0;
    logic                busy_q = 1'b0;
    int                  wr_cyc [BUF_DEPTH];
    logic [PTR_W-1:0]    wr_addr [BUF_DEPTH];
    logic [SAMPLE_W-1:0] got [BUF_DEPTH];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (busy && !busy_q) begin
            first_issue_cyc = cyc;
            first_addr      = in_addr;
        end
        busy_q = busy;
        if (out_we) begin
            if (wr_cnt < BUF_DEPTH) begin
                wr_cyc[wr_cnt]  = cyc;
                wr_addr[wr_cnt] = out_addr;
            end
            got[out_addr] = out_sample;
            wr_cnt++;
        end
        if (done) begin
            done_cyc = cyc;
            done_cnt++;
`ifdef CHUNK_PEAK_EN
            peak_at_done = peak_abs;
`endif
        end
    end

    task automatic clear_capture();
        wr_cnt = 0;
        for (int i = 0; i < BUF_DEPTH; i++) got[i] = 24'hA5A5A5;
    endtask

    task automatic pulse_chunk();
        @(negedge clk) chunk_pulse = 1'b1;
        repeat (3) @(negedge clk);
        chunk_pulse = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
        check(tag, done_cnt - d0, 1);
    endtask

    task automatic run_chunk(input string tag);
        int d0;
        clear_capture();
        d0 = done_cnt;
        pulse_chunk();
        wait_done(tag, d0);
        @(negedge clk);
    endtask

    task automatic check_ramp(input string tag);
        int errs = 0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (got[i] !== 24'(i * 1000)) errs++;
            if (wr_addr[i] !== PTR_W'(i)) errs++;
        end
        check(tag, errs, 0);
    endtask

    task automatic check_const(input string tag, input logic [SAMPLE_W-1:0] exp);
        int errs = 0;
        for (int i = 0; i < BUF_DEPTH; i++)
            if (got[i] !== exp) errs++;
        check(tag, errs, 0);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < BUF_DEPTH; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", out_we, 0);
        check("rst_overrun", overrun, 0);
        check("rst_in_addr", in_addr, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_sample", out_sample, 0);

        // 1: unity gain ramp, latency and contiguity
        for (int i = 0; i < BUF_DEPTH; i++) mem[i] = 24'(i * 1000);
        gain = 16'h4000;
        run_chunk("t1_done");
        check("t1_wr_cnt", wr_cnt, 64);
        check_ramp("t1_data");
        check("t1_first_addr", first_addr, 0);
        check("t1_latency", wr_cyc[0] - first_issue_cyc, 3);
        check("t1_contig", wr_cyc[63] - wr_cyc[0], 63);
        check("t1_done_lat", done_cyc - wr_cyc[63], 1);
        check("t1_busy_idle", busy, 0);
        check("t1_addr_hold", in_addr, 63);
        check("t1_we_idle", out_we, 0);

        // 2: saturation both ways
        gain = 16'h7FFF;
        for (int i = 0; i < BUF_DEPTH; i++) mem[i] = 24'h7FFFFF;
        run_chunk("t2p_done");
        check_const("t2_sat_pos", 24'h7FFFFF);
        for (int i = 0; i < BUF_DEPTH; i++) mem[i] = 24'h800000;
        run_chunk("t2n_done");
        check_const("t2_sat_neg", 24'h800000);

        // 3: rounding with gain 0.5, gain changed mid-chunk must be ignored
        for (int i = 0; i < BUF_DEPTH; i++) mem[i] = '0;
        mem[0]  = 24'd3;
        mem[1]  = 24'hFFFFFD;
        mem[40] = 24'd16384;
        gain = 16'h2000;
        clear_capture();
        w0 = done_cnt;
        pulse_chunk();
        for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
        gain = 16'h0000;
        wait_done("t3_done", w0);
        check("t3_round_pos", got[0], 24'd2);
        check("t3_round_neg", got[1], 24'hFFFFFF);
        check("t3_gain_held", got[40], 24'd8192);
        check("t3_zero", got[2], 24'd0);

        // 4: second pulse while busy -> overrun, no extra writes
        for (int i = 0; i < BUF_DEPTH; i++) mem[i] = 24'(i * 1000);
        gain = 16'h4000;
        clear_capture();
        w0 = done_cnt;
        pulse_chunk();
        for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        pulse_chunk();
        wait_done("t4_done", w0);
        repeat (20) @(negedge clk);
        check("t4_overrun", overrun, 1);
        check("t4_wr_cnt", wr_cnt, 64);
        check("t4_done_cnt", done_cnt - w0, 1);
        run_chunk("t4_next_done");
        check("t4_next_wr_cnt", wr_cnt, 64);
        check_ramp("t4_next_data");
        check("t4_overrun_sticky", overrun, 1);

        // 5: reset mid-chunk
        clear_capture();
        pulse_chunk();
        for (int i = 0; i < 200 && wr_cnt < 20; i++) @(negedge clk);
        check("t5_reached_20", wr_cnt, 20);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_busy", busy, 0);
        check("t5_overrun", overrun, 0);
        check("t5_we", out_we, 0);
        w0 = wr_cnt;
        repeat (20) @(negedge clk);
        check("t5_no_writes", wr_cnt - w0, 0);
        run_chunk("t5_fresh_done");
        check("t5_fresh_wr_cnt", wr_cnt, 64);
        check_ramp("t5_fresh_data");

`ifdef CHUNK_PEAK_EN
        // 6: peak magnitude reported with done
        for (int i = 0; i < BUF_DEPTH; i++) mem[i] = 24'd100;
        mem[7] = 24'(-500000);
        gain = 16'h4000;
        run_chunk("t6_done");
        check("t6_peak", peak_at_done, 500000);
        check("t6_peak_hold", peak_abs, 500000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end expected finish");
        $fatal(1, "timeout");
    end

endmodule
